// File: rtl/wishbone_master.sv
// rtl/wishbone_master.sv - command-driven Wishbone B4 initiator with staged write FIFO
module wishbone_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [4:0]            cmd_len_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  input  logic                  cmd_tag_add_i,
  input  logic                  wr_push_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_full_o,
  output logic [4:0]            wr_count_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  done_o,
  output logic [1:0]            status_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  we_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  output logic [2:0]            cti_o,
  output logic                  tag_add_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i
);

  localparam int PTR_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [4:0]       MAX_LEN  = 5'(MAX_BURST);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_BURST - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic [4:0]        len_q;
  logic              we_q;
  logic [4:0]        beat_cnt;
  logic [4:0]        resp_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              err_flag;

  logic [DATA_WIDTH-1:0] fifo_mem [MAX_BURST];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push_ok;
  logic                  fifo_pop;

  logic       eff_we;
  logic [4:0] eff_len;
  logic       reject;
  logic       accept;
  logic       more_beats;

  logic       in_bus;
  logic       resp;
  logic       counted;
  logic [4:0] resp_cnt_nxt;
  logic       err_nxt;
  logic       all_resp;
  logic       timed_out;
  logic       finish;

  assign wr_full_o = (wr_count_o == MAX_LEN);
  assign push_ok   = wr_push_i && !wr_full_o;
  assign fifo_head = fifo_mem[rd_ptr];

  // Tag-add overrides direction and length before any legality check.
  assign eff_we     = cmd_we_i && !cmd_tag_add_i;
  assign eff_len    = cmd_tag_add_i ? 5'd1 : cmd_len_i;
  assign reject     = (eff_len == 5'd0) || (eff_len > MAX_LEN) || (eff_we && (wr_count_o < eff_len));
  assign accept     = (state == IDLE) && cmd_valid_i;
  assign more_beats = (state == ISSUE) && (beat_cnt != len_q);
  assign fifo_pop   = (accept && !reject && eff_we) || (more_beats && we_q);

  // Responses beyond the command length are ignored entirely.
  assign in_bus       = (state == ISSUE) || (state == WAIT);
  assign resp         = in_bus && (ack_i || err_i);
  assign counted      = resp && (resp_cnt < len_q);
  assign resp_cnt_nxt = resp_cnt + {4'd0, counted};
  assign err_nxt      = err_flag || (counted && err_i);
  assign all_resp     = (resp_cnt_nxt == len_q);
  assign timed_out    = !resp && (to_cnt == TO_LAST);
  assign finish       = (state == WAIT) && (all_resp || timed_out);

  // Write-FIFO storage, no reset needed on the data array.
  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr] <= wr_data_i;
  end

  // Write-FIFO pointers and occupancy; pushes accepted in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      wr_count_o <= 5'd0;
    end else begin
      if (push_ok)  wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, fifo_pop})
        2'b10:   wr_count_o <= wr_count_o + 5'd1;
        2'b01:   wr_count_o <= wr_count_o - 5'd1;
        default: wr_count_o <= wr_count_o;
      endcase
    end
  end

  // Command FSM with registered bus request, response counting and completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      len_q       <= 5'd0;
      we_q        <= 1'b0;
      beat_cnt    <= 5'd0;
      resp_cnt    <= 5'd0;
      to_cnt      <= '0;
      err_flag    <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_data_o   <= '0;
      done_o      <= 1'b0;
      status_o    <= 2'b00;
      addr_o      <= '0;
      data_o      <= '0;
      we_o        <= 1'b0;
      sel_o       <= '0;
      stb_o       <= 1'b0;
      cyc_o       <= 1'b0;
      cti_o       <= 3'b000;
      tag_add_o   <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      if (in_bus) begin
        resp_cnt <= resp_cnt_nxt;
        err_flag <= err_nxt;
        if (resp) to_cnt <= '0;
        if (counted && ack_i && !err_i && !we_q) begin
          rd_data_o  <= data_i;
          rd_valid_o <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            len_q       <= eff_len;
            we_q        <= eff_we;
            resp_cnt    <= 5'd0;
            err_flag    <= 1'b0;
            to_cnt      <= '0;
            if (reject) begin
              state    <= DONE;
              done_o   <= 1'b1;
              status_o <= 2'b11;
            end else begin
              state     <= ISSUE;
              beat_cnt  <= 5'd1;
              cyc_o     <= 1'b1;
              stb_o     <= 1'b1;
              addr_o    <= cmd_addr_i;
              sel_o     <= cmd_sel_i;
              we_o      <= eff_we;
              tag_add_o <= cmd_tag_add_i;
              cti_o     <= (eff_len == 5'd1) ? 3'b000 : 3'b010;
              data_o    <= eff_we ? fifo_head : '0;
            end
          end
        end
        ISSUE: begin
          to_cnt <= '0;
          if (more_beats) begin
            beat_cnt <= beat_cnt + 5'd1;
            data_o   <= we_q ? fifo_head : '0;
          end else begin
            stb_o  <= 1'b0;
            data_o <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (finish) begin
            state     <= DONE;
            done_o    <= 1'b1;
            status_o  <= all_resp ? {1'b0, err_nxt} : 2'b10;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            tag_add_o <= 1'b0;
            addr_o    <= '0;
            sel_o     <= '0;
            cti_o     <= 3'b000;
            data_o    <= '0;
          end else if (!resp) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE: begin
          status_o    <= 2'b00;
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
// tb/tb_wishbone_master.sv - self-checking bench for wishbone_master with a behavioural slave
module tb_wishbone_master;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_tag_add_i;
  logic [4:0]  cmd_addr_i, cmd_len_i;
  logic [3:0]  cmd_sel_i;
  logic        wr_push_i, wr_full_o;
  logic [31:0] wr_data_i;
  logic [4:0]  wr_count_o;
  logic        rd_valid_o, done_o;
  logic [31:0] rd_data_o;
  logic [1:0]  status_o;
  logic [4:0]  addr_o;
  logic [31:0] data_o, data_i;
  logic        we_o, stb_o, cyc_o, tag_add_o, ack_i, err_i;
  logic [3:0]  sel_o;
  logic [2:0]  cti_o;

  always #5 clk_i = ~clk_i;

  wishbone_master #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .MAX_BURST(16), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
    .cmd_tag_add_i(cmd_tag_add_i), .wr_push_i(wr_push_i), .wr_data_i(wr_data_i),
    .wr_full_o(wr_full_o), .wr_count_o(wr_count_o), .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o), .done_o(done_o), .status_o(status_o),
    .addr_o(addr_o), .data_o(data_o), .we_o(we_o), .sel_o(sel_o), .stb_o(stb_o),
    .cyc_o(cyc_o), .cti_o(cti_o), .tag_add_o(tag_add_o),
    .ack_i(ack_i), .err_i(err_i), .data_i(data_i)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // Behavioural slave: registered one-cycle response, internal burst counter cleared while cyc_o is low.
  logic [31:0] smem [16];
  int          bcnt;
  int          sa;
  logic [3:0]  sa_lo;
  logic        slave_mute;
  assign sa    = int'(addr_o) + bcnt;
  assign sa_lo = sa[3:0];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_i  <= 1'b0;
      err_i  <= 1'b0;
      data_i <= '0;
      bcnt   <= 0;
      for (int i = 0; i < 16; i++) smem[i] <= pat(i);
    end else begin
      ack_i <= 1'b0;
      err_i <= 1'b0;
      if (!cyc_o) bcnt <= 0;
      else if (stb_o && !slave_mute) begin
        bcnt <= bcnt + 1;
        if (sa > 15) err_i <= 1'b1;
        else begin
          ack_i <= 1'b1;
          if (we_o) begin
            for (int b = 0; b < 4; b++) if (sel_o[b]) smem[sa_lo][8*b +: 8] <= data_o[8*b +: 8];
          end else if (tag_add_o) data_i <= smem[sa_lo] + smem[sa_lo + 4'd1];
          else data_i <= smem[sa_lo];
        end
      end
    end
  end

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] fifo_model [$];
  logic [31:0] exp_rd [$];
  logic [31:0] exp_wd [$];
  logic [31:0] got_rd [$];
  logic [31:0] got_wd [$];
  int          rd_off [$];

  int          r_done_off, r_stb_cnt, r_bad_beat, r_cyc_seen;
  logic [1:0]  r_status;
  logic [2:0]  r_cti;
  logic        r_we, r_tag, r_cyc_at_done, r_ready_ok;
  logic [31:0] e, g;

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      wr_push_i = 1'b1;
      wr_data_i = base + 32'(i);
      if (fifo_model.size() < 16) fifo_model.push_back(base + 32'(i));
    end
    @(negedge clk_i);
    wr_push_i = 1'b0;
  endtask

  // Issues one command and records what the bus and result ports did, offset 1 = cycle after handshake.
  task automatic do_cmd(input logic we, input logic [4:0] addr, input logic [4:0] len, input logic tag);
    got_rd.delete(); got_wd.delete(); rd_off.delete();
    r_done_off = -1; r_stb_cnt = 0; r_bad_beat = 0; r_cyc_seen = 0;
    r_status = 2'bxx; r_cti = 3'bxxx; r_we = 1'bx; r_tag = 1'bx; r_cyc_at_done = 1'bx;
    @(negedge clk_i);
    r_ready_ok = cmd_ready_o;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = len;
    cmd_sel_i = 4'hF; cmd_tag_add_i = tag;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0; cmd_tag_add_i = 1'b0;
    for (int off = 1; off <= 60; off++) begin
      @(negedge clk_i);
      if (cyc_o) r_cyc_seen = 1;
      if (stb_o) begin
        r_stb_cnt++;
        if (r_stb_cnt == 1) begin r_cti = cti_o; r_we = we_o; r_tag = tag_add_o; end
        if (cti_o !== r_cti || addr_o !== addr) r_bad_beat++;
        if (we_o) got_wd.push_back(data_o);
      end
      if (rd_valid_o) begin got_rd.push_back(rd_data_o); rd_off.push_back(off); end
      if (done_o) begin
        r_done_off = off; r_status = status_o; r_cyc_at_done = cyc_o;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = 0; cmd_len_i = 0;
    cmd_sel_i = 0; cmd_tag_add_i = 0; wr_push_i = 0; wr_data_i = 0; slave_mute = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = pat(i);
    repeat (3) @(negedge clk_i);
    tests_run++;
    if (cmd_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", cmd_ready_o); end
    tests_run++;
    if ({cyc_o, stb_o, we_o, tag_add_o, done_o, rd_valid_o, wr_full_o} !== 7'd0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b want 0000000", {cyc_o, stb_o, we_o, tag_add_o, done_o, rd_valid_o, wr_full_o});
    end
    tests_run++;
    if ({addr_o, data_o, sel_o, cti_o, status_o, rd_data_o, wr_count_o} !== '0) begin
      tests_failed++; $display("FAIL reset_data: got %h want 0", {addr_o, data_o, sel_o, cti_o, status_o, rd_data_o, wr_count_o});
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single;
    push_words(32'hA5A5_0001, 1);
    e = fifo_model.pop_front(); ref_mem[3] = e;
    do_cmd(1'b1, 5'd3, 5'd1, 1'b0);
    tests_run++; if (r_ready_ok !== 1'b1) begin tests_failed++; $display("FAIL single_ready: got %b want 1", r_ready_ok); end
    tests_run++; if (r_stb_cnt != 1) begin tests_failed++; $display("FAIL single_wr_beats: got %0d want 1", r_stb_cnt); end
    tests_run++; if ({r_cti, r_we} !== 4'b0001) begin tests_failed++; $display("FAIL single_wr_cti_we: got %b want 0001", {r_cti, r_we}); end
    g = (got_wd.size() > 0) ? got_wd[0] : 32'hDEAD_BEEF;
    tests_run++; if (g !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL single_wr_data: got %h want a5a50001", g); end
    tests_run++; if (r_done_off != 3 || r_status !== 2'b00) begin
      tests_failed++; $display("FAIL single_wr_done: got off %0d st %b want off 3 st 00", r_done_off, r_status);
    end
    @(negedge clk_i);
    tests_run++; if (cmd_ready_o !== 1'b1) begin tests_failed++; $display("FAIL single_ready_back: got %b want 1", cmd_ready_o); end
    exp_rd.push_back(ref_mem[3]);
    do_cmd(1'b0, 5'd3, 5'd1, 1'b0);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); tests_run++;
      if (got_rd.size() == 0) begin tests_failed++; $display("FAIL single_rd_data: got none want %h", e); end
      else begin g = got_rd.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL single_rd_data: got %h want %h", g, e); end end
    end
    tests_run++; if (r_done_off != 3) begin tests_failed++; $display("FAIL single_rd_done: got %0d want 3", r_done_off); end
  endtask

  task automatic test_burst;
    push_words(32'hB000_0010, 4);
    for (int i = 0; i < 4; i++) begin e = fifo_model.pop_front(); exp_wd.push_back(e); ref_mem[4 + i] = e; end
    do_cmd(1'b1, 5'd4, 5'd4, 1'b0);
    tests_run++; if (r_stb_cnt != 4 || r_bad_beat != 0 || r_cti !== 3'b010) begin
      tests_failed++; $display("FAIL burst_wr_beats: got %0d beats %0d bad cti %b want 4 0 010", r_stb_cnt, r_bad_beat, r_cti);
    end
    while (exp_wd.size() > 0) begin
      e = exp_wd.pop_front(); tests_run++;
      g = (got_wd.size() > 0) ? got_wd.pop_front() : 32'hDEAD_BEEF;
      if (g !== e) begin tests_failed++; $display("FAIL burst_wr_data: got %h want %h", g, e); end
    end
    tests_run++; if (wr_count_o !== 5'd0) begin tests_failed++; $display("FAIL burst_fifo_empty: got %0d want 0", wr_count_o); end
    for (int i = 4; i < 8; i++) exp_rd.push_back(ref_mem[i]);
    do_cmd(1'b0, 5'd4, 5'd4, 1'b0);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); tests_run++;
      if (got_rd.size() == 0) begin tests_failed++; $display("FAIL burst_rd_data: got none want %h", e); end
      else begin g = got_rd.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL burst_rd_data: got %h want %h", g, e); end end
    end
    tests_run++; if (r_done_off != 6) begin tests_failed++; $display("FAIL burst_rd_done: got %0d want 6", r_done_off); end
    tests_run++; if (rd_off.size() != 4 || rd_off[0] != 3 || rd_off[3] != 6) begin
      tests_failed++; $display("FAIL burst_rd_timing: got %0d strobes want 4 at offsets 3..6", rd_off.size());
    end
  endtask

  task automatic test_err;
    exp_rd.push_back(ref_mem[14]); exp_rd.push_back(ref_mem[15]);
    do_cmd(1'b0, 5'd14, 5'd4, 1'b0);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); tests_run++;
      if (got_rd.size() == 0) begin tests_failed++; $display("FAIL err_rd_data: got none want %h", e); end
      else begin g = got_rd.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL err_rd_data: got %h want %h", g, e); end end
    end
    tests_run++; if (got_rd.size() != 0) begin tests_failed++; $display("FAIL err_extra_strobes: got %0d extra want 0", got_rd.size()); end
    tests_run++; if (r_done_off != 6 || r_status !== 2'b01) begin
      tests_failed++; $display("FAIL err_done: got off %0d st %b want off 6 st 01", r_done_off, r_status);
    end
  endtask

  task automatic test_reject_and_full;
    push_words(32'hC000_0000, 2);
    do_cmd(1'b1, 5'd0, 5'd3, 1'b0);
    tests_run++; if (r_done_off != 1 || r_status !== 2'b11 || r_cyc_seen != 0) begin
      tests_failed++; $display("FAIL reject_short_fifo: got off %0d st %b cyc %0d want 1 11 0", r_done_off, r_status, r_cyc_seen);
    end
    tests_run++; if (wr_count_o !== 5'd2) begin tests_failed++; $display("FAIL reject_no_pop: got %0d want 2", wr_count_o); end
    do_cmd(1'b0, 5'd0, 5'd0, 1'b0);
    tests_run++; if (r_done_off != 1 || r_status !== 2'b11) begin
      tests_failed++; $display("FAIL reject_len0: got off %0d st %b want 1 11", r_done_off, r_status);
    end
    push_words(32'hD000_0000, 17);
    tests_run++; if (wr_full_o !== 1'b1 || wr_count_o !== 5'd16) begin
      tests_failed++; $display("FAIL fifo_full: got full %b count %0d want 1 16", wr_full_o, wr_count_o);
    end
    do_cmd(1'b0, 5'd0, 5'd17, 1'b0);
    tests_run++; if (r_done_off != 1 || r_status !== 2'b11 || r_cyc_seen != 0) begin
      tests_failed++; $display("FAIL reject_len17: got off %0d st %b cyc %0d want 1 11 0", r_done_off, r_status, r_cyc_seen);
    end
    for (int i = 0; i < 16; i++) begin e = fifo_model.pop_front(); exp_wd.push_back(e); ref_mem[i] = e; end
    do_cmd(1'b1, 5'd0, 5'd16, 1'b0);
    tests_run++; if (r_stb_cnt != 16 || r_bad_beat != 0 || r_done_off != 18 || r_status !== 2'b00) begin
      tests_failed++; $display("FAIL max_burst: got beats %0d bad %0d off %0d st %b want 16 0 18 00", r_stb_cnt, r_bad_beat, r_done_off, r_status);
    end
    while (exp_wd.size() > 0) begin
      e = exp_wd.pop_front(); tests_run++;
      g = (got_wd.size() > 0) ? got_wd.pop_front() : 32'hDEAD_BEEF;
      if (g !== e) begin tests_failed++; $display("FAIL max_burst_data: got %h want %h", g, e); end
    end
    tests_run++; if (wr_full_o !== 1'b0 || wr_count_o !== 5'd0) begin
      tests_failed++; $display("FAIL max_burst_drain: got full %b count %0d want 0 0", wr_full_o, wr_count_o);
    end
  endtask

  task automatic test_timeout;
    slave_mute = 1'b1;
    do_cmd(1'b0, 5'd2, 5'd1, 1'b0);
    tests_run++; if (r_done_off != 10 || r_status !== 2'b10) begin
      tests_failed++; $display("FAIL timeout_done: got off %0d st %b want 10 10", r_done_off, r_status);
    end
    tests_run++; if (r_cyc_at_done !== 1'b0 || got_rd.size() != 0) begin
      tests_failed++; $display("FAIL timeout_bus: got cyc %b strobes %0d want 0 0", r_cyc_at_done, got_rd.size());
    end
    slave_mute = 1'b0;
  endtask

  task automatic test_reset_mid;
    int done_seen;
    push_words(32'hE000_0000, 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 5'd0; cmd_len_i = 5'd4; cmd_tag_add_i = 1'b0;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    tests_run++; if ({cyc_o, stb_o, done_o, rd_valid_o, we_o, tag_add_o} !== 6'd0 || cmd_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_ctrl: got %b ready %b want 000000 ready 1", {cyc_o, stb_o, done_o, rd_valid_o, we_o, tag_add_o}, cmd_ready_o);
    end
    tests_run++; if ({addr_o, data_o, sel_o, cti_o, status_o, rd_data_o, wr_count_o} !== '0) begin
      tests_failed++; $display("FAIL midreset_data: got %h want 0", {addr_o, data_o, sel_o, cti_o, status_o, rd_data_o, wr_count_o});
    end
    done_seen = 0;
    for (int i = 0; i < 2; i++) begin @(negedge clk_i); if (done_o) done_seen++; end
    rst_ni = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = pat(i);
    fifo_model.delete();
    for (int i = 0; i < 3; i++) begin @(negedge clk_i); if (done_o) done_seen++; end
    tests_run++; if (done_seen != 0) begin tests_failed++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_seen); end
    exp_rd.push_back(ref_mem[0] + ref_mem[1]);
    do_cmd(1'b1, 5'd0, 5'd3, 1'b1);
    tests_run++; if (r_stb_cnt != 1 || r_tag !== 1'b1 || r_we !== 1'b0) begin
      tests_failed++; $display("FAIL tag_bus: got beats %0d tag %b we %b want 1 1 0", r_stb_cnt, r_tag, r_we);
    end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); tests_run++;
      if (got_rd.size() == 0) begin tests_failed++; $display("FAIL tag_rd_data: got none want %h", e); end
      else begin g = got_rd.pop_front(); if (g !== e) begin tests_failed++; $display("FAIL tag_rd_data: got %h want %h", g, e); end end
    end
    tests_run++; if (r_done_off != 3 || r_status !== 2'b00) begin
      tests_failed++; $display("FAIL tag_done: got off %0d st %b want 3 00", r_done_off, r_status);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_err();
    test_reject_and_full();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
